// File: rtl/vdec1_pkg.sv
// rtl/vdec1_pkg.sv - shared constants, FSM encoding and encoder parity helper for vdec1
// Used by vdec1_fwd, vdec1_acs_bfly and the vdec1 encoder model.
package vdec1_pkg;

  localparam int SW  = 6;   // soft-value width (signed)
  localparam int PMW = 12;  // path-metric width, modulo arithmetic

  localparam logic [8:0] G0 = 9'o557;
  localparam logic [8:0] G1 = 9'o663;
  localparam logic [8:0] G2 = 9'o711;

  // Non-zero states start well below state 0 so the trellis is anchored at state 0.
  localparam logic [PMW-1:0] PM_INIT = 12'hE00;

  localparam int TAIL_LEN = 8;
  localparam int MAX_STEP = 36;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_ACS,
    ST_FIN
  } fwd_state_e;

  // w = {oldest .. newest}; w[0] is the newest input bit. Returns {c2,c1,c0}.
  function automatic logic [2:0] parity3(input logic [8:0] w);
    return {^(w & G2), ^(w & G1), ^(w & G0)};
  endfunction

endpackage

// File: rtl/vdec1_acs_bfly.sv
// rtl/vdec1_acs_bfly.sv - one add-compare-select butterfly for a single trellis state
// Ports:
//   pm0_i  old metric of predecessor {0, s[7:1]}
//   pm1_i  old metric of predecessor {1, s[7:1]}
//   sym_i  soft triplet {y2,y1,y0}, each signed SW bits
//   s_i    destination state
//   pm_o   new metric for s_i
//   dec_o  survivor decision (1 = predecessor with leading 1)
module vdec1_acs_bfly
  import vdec1_pkg::*;
(
  input  logic [PMW-1:0]  pm0_i,
  input  logic [PMW-1:0]  pm1_i,
  input  logic [3*SW-1:0] sym_i,
  input  logic [7:0]      s_i,
  output logic [PMW-1:0]  pm_o,
  output logic            dec_o
);

  function automatic logic [PMW-1:0] sx(input logic [SW-1:0] v);
    return {{(PMW-SW){v[SW-1]}}, v};
  endfunction

  // Positive soft value means code bit 0, so a matching bit adds y and a 1 subtracts it.
  function automatic logic [PMW-1:0] branch_metric(input logic [2:0] c, input logic [3*SW-1:0] y);
    logic [PMW-1:0] y0, y1, y2;
    y0 = sx(y[SW-1:0]);
    y1 = sx(y[2*SW-1:SW]);
    y2 = sx(y[3*SW-1:2*SW]);
    return (c[0] ? -y0 : y0) + (c[1] ? -y1 : y1) + (c[2] ? -y2 : y2);
  endfunction

  logic [PMW-1:0] m0;
  logic [PMW-1:0] m1;
  logic [PMW-1:0] diff;

  always_comb begin
    m0    = pm0_i + branch_metric(parity3({1'b0, s_i}), sym_i);
    m1    = pm1_i + branch_metric(parity3({1'b1, s_i}), sym_i);
    // Metrics wrap freely; the sign of the modular difference orders them. Ties keep d = 0.
    diff  = m1 - m0;
    dec_o = ~diff[PMW-1] && (m1 != m0);
    pm_o  = dec_o ? m1 : m0;
  end

endmodule

// File: rtl/vdec1_fwd.sv
// rtl/vdec1_fwd.sv - forward ACS stage of the rate-1/3 K=9 Viterbi decoder
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start_i        one-cycle pulse, begins a decode (ignored unless idle)
//   step_last_i    index of last trellis step, sampled on start
//   busy_o         high from the cycle after start until done
//   done_o         one-cycle pulse after the last ptram write
//   sym_rd_o       symbol buffer read strobe, data returned next cycle
//   sym_addr_o     trellis step being read
//   sym_dout_i     {y2,y1,y0} soft triplet
//   pt_wr_o        ptram write strobe
//   pt_addr_o      {step, grp}
//   pt_din_o       bit k = decision for state {grp, k}
module vdec1_fwd
  import vdec1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  step_last_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sym_rd_o,
  output logic [5:0]  sym_addr_o,
  input  logic [17:0] sym_dout_i,
  output logic        pt_wr_o,
  output logic [8:0]  pt_addr_o,
  output logic [31:0] pt_din_o
);

  fwd_state_e  state_q, state_d;
  logic [5:0]  step_q, step_d;
  logic [5:0]  step_last_q, step_last_d;
  logic [2:0]  grp_q, grp_d;
  logic        bank_q, bank_d;
  logic [17:0] sym_q, sym_d;
  logic        init_pm;
  logic        acs_en;

  // Ping-pong metric banks: bank_q is read, the other bank is written.
  logic [PMW-1:0] pm_q [0:1][0:255];

  logic [17:0]    sym_cur;
  logic [PMW-1:0] new_pm [0:31];
  logic [31:0]    dec;

  // The read returns during grp 0, so grp 0 consumes the bus directly while it is captured.
  assign sym_cur = (grp_q == 3'd0) ? sym_dout_i : sym_q;

  for (genvar k = 0; k < 32; k++) begin : g_bfly
    localparam logic [4:0] KI = 5'(k);
    vdec1_acs_bfly u_bfly (
      .pm0_i (pm_q[bank_q][{1'b0, grp_q, KI[4:1]}]),
      .pm1_i (pm_q[bank_q][{1'b1, grp_q, KI[4:1]}]),
      .sym_i (sym_cur),
      .s_i   ({grp_q, KI}),
      .pm_o  (new_pm[k]),
      .dec_o (dec[k])
    );
  end

  always_ff @(posedge clk) begin
    if (init_pm) begin
      for (int i = 0; i < 256; i++) begin
        pm_q[0][i] <= (i == 0) ? '0 : PM_INIT;
      end
    end else if (acs_en) begin
      for (int k = 0; k < 32; k++) begin
        pm_q[~bank_q][{grp_q, 5'(k)}] <= new_pm[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    step_last_d = step_last_q;
    grp_d       = grp_q;
    bank_d      = bank_q;
    sym_d       = sym_q;
    init_pm     = 1'b0;
    acs_en      = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    sym_rd_o    = 1'b0;
    sym_addr_o  = '0;
    pt_wr_o     = 1'b0;
    pt_addr_o   = '0;
    pt_din_o    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_RD;
          step_d      = '0;
          grp_d       = '0;
          bank_d      = 1'b0;
          step_last_d = step_last_i;
          init_pm     = 1'b1;
        end
      end
      ST_RD: begin
        busy_o     = 1'b1;
        sym_rd_o   = 1'b1;
        sym_addr_o = step_q;
        state_d    = ST_ACS;
      end
      ST_ACS: begin
        busy_o    = 1'b1;
        acs_en    = 1'b1;
        pt_wr_o   = 1'b1;
        pt_addr_o = {step_q, grp_q};
        pt_din_o  = dec;
        if (grp_q == 3'd0) begin
          sym_d = sym_dout_i;
        end
        grp_d = grp_q + 3'd1;
        if (grp_q == 3'd7) begin
          bank_d = ~bank_q;
          if (step_q == step_last_q) begin
            state_d = ST_FIN;
          end else begin
            step_d  = step_q + 6'd1;
            state_d = ST_RD;
          end
        end
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      step_last_q <= '0;
      grp_q       <= '0;
      bank_q      <= 1'b0;
      sym_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      step_last_q <= step_last_d;
      grp_q       <= grp_d;
      bank_q      <= bank_d;
      sym_q       <= sym_d;
    end
  end

endmodule
